// File: rtl/lcd_scan_ctrl.sv
`default_nettype none
// lcd_scan_ctrl: CL2/CL1/FLM/M scan timing plus frame-RAM pixel path for passive STN LCDs.
// Build options: LCD_TESTPAT_EN (checkerboard source), LCD_MLINE_EN (M toggles every M_LINES lines).
module lcd_scan_ctrl #(
  parameter int CLK_DIV = 50,
  parameter int COLS    = 240,
  parameter int LINES   = 64,
  parameter int DATA_W  = 4,
  parameter int M_LINES = 13,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              testpat,
  output logic              lcd_cl2,
  output logic              lcd_cl1,
  output logic              lcd_flm,
  output logic              lcd_m,
  output logic [DATA_W-1:0] lcd_d,
  output logic              frame_start
);

  localparam int SPL   = COLS / DATA_W;
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SH_W  = (SPL > 1) ? $clog2(SPL) : 1;
  localparam int LN_W  = (LINES > 2) ? $clog2(LINES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [SH_W-1:0]  SHIFT_LAST = SH_W'(SPL - 1);
  localparam logic [LN_W-1:0]  LINE_LAST  = LN_W'(LINES - 1);

  if (CLK_DIV < 2 || LINES < 2 || DATA_W < 1 || M_LINES < 1 || COLS < DATA_W ||
      (COLS % DATA_W) != 0 || ADDR_W < $clog2(LINES * (COLS / DATA_W))) begin : g_param_check
    $error("lcd_scan_ctrl: illegal parameter combination");
  end

  logic [DIV_W-1:0]  div;
  logic [SH_W-1:0]   shift;
  logic [LN_W-1:0]   line;
  logic [DATA_W-1:0] data_src;
  logic              tick, rise_tick, fall_tick;
  logic              last_shift, last_line, m_toggle;

  assign tick       = (div == DIV_LAST);
  assign rise_tick  = tick & ~lcd_cl2;
  assign fall_tick  = tick & lcd_cl2;
  assign last_shift = (shift == SHIFT_LAST);
  assign last_line  = (line == LINE_LAST);

`ifdef LCD_TESTPAT_EN
  logic [DATA_W-1:0] pattern;
  for (genvar i = 0; i < DATA_W; i++) begin : g_pattern
    assign pattern[i] = line[0] ^ shift[0] ^ ((i % 2) == 1);
  end
  assign data_src = testpat ? pattern : pix_data;
`else
  logic unused_testpat;
  assign unused_testpat = testpat;
  assign data_src       = pix_data;
`endif

`ifdef LCD_MLINE_EN
  localparam int MC_W = (M_LINES > 2) ? $clog2(M_LINES) : 1;
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(M_LINES - 1);
  logic [MC_W-1:0] mcnt;

  // Line counter for M runs across frame boundaries; only en=0/reset restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt <= '0;
    end else if (!en) begin
      mcnt <= '0;
    end else if (fall_tick && last_shift) begin
      mcnt <= (mcnt == MC_LAST) ? '0 : mcnt + 1'b1;
    end
  end
  assign m_toggle = last_shift & (mcnt == MC_LAST);
`else
  assign m_toggle = last_shift & last_line;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      shift       <= '0;
      line        <= '0;
      pix_addr    <= '0;
      lcd_cl2     <= 1'b0;
      lcd_cl1     <= 1'b0;
      lcd_flm     <= 1'b0;
      lcd_m       <= 1'b0;
      lcd_d       <= '0;
      frame_start <= 1'b0;
    end else if (!en) begin
      div         <= '0;
      shift       <= '0;
      line        <= '0;
      pix_addr    <= '0;
      lcd_cl2     <= 1'b0;
      lcd_cl1     <= 1'b0;
      lcd_flm     <= 1'b0;
      lcd_d       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      div         <= tick ? '0 : div + 1'b1;
      if (tick) lcd_cl2 <= ~lcd_cl2;
      // RAM word for this shift has been valid since the clk after the falling tick.
      if (rise_tick) begin
        lcd_d       <= data_src;
        lcd_cl1     <= 1'b0;
        frame_start <= (shift == '0) && (line == '0);
      end
      if (fall_tick) begin
        shift    <= last_shift ? '0 : shift + 1'b1;
        if (last_shift) line <= last_line ? '0 : line + 1'b1;
        pix_addr <= (last_shift && last_line) ? '0 : pix_addr + 1'b1;
        lcd_cl1  <= last_shift;
        lcd_flm  <= (line == '0);
        if (m_toggle) lcd_m <= ~lcd_m;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_scan_ctrl.sv
`default_nettype none
// tb_lcd_scan_ctrl: random en/rst stimulus checked every clock against a timeline model.
module tb_lcd_scan_ctrl;
  localparam int CLK_DIV = 2;
  localparam int COLS    = 8;
  localparam int LINES   = 3;
  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 5;
`ifdef LCD_MLINE_EN
  localparam int M_LINES = 2;
`else
  localparam int M_LINES = 13;
`endif
  localparam int SPL   = COLS / DATA_W;
  localparam int FRAME = SPL * LINES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              testpat = 1'b0;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data = '0;
  logic              lcd_cl2, lcd_cl1, lcd_flm, lcd_m, frame_start;
  logic [DATA_W-1:0] lcd_d;
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;
  int n = 0;            // enabled clock edges since the scan (re)started
  logic m_base = 1'b0;  // lcd_m value when the scan (re)started

  lcd_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .COLS(COLS), .LINES(LINES), .DATA_W(DATA_W),
    .M_LINES(M_LINES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_addr(pix_addr), .pix_data(pix_data),
    .testpat(testpat), .lcd_cl2(lcd_cl2), .lcd_cl1(lcd_cl1), .lcd_flm(lcd_flm),
    .lcd_m(lcd_m), .lcd_d(lcd_d), .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pix_data <= ram[pix_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  function automatic int addr_of(input int p);
    return (((p / SPL) % LINES) * SPL + (p % SPL)) % (1 << ADDR_W);
  endfunction

  // Pixel word shown for shift position p (p counts shifts since scan start).
  function automatic logic [DATA_W-1:0] data_of(input int p);
    logic [DATA_W-1:0] d;
`ifdef LCD_TESTPAT_EN
    for (int i = 0; i < DATA_W; i++) d[i] = 1'(((p / SPL) % LINES + (p % SPL) + i) % 2);
`else
    d = ram[addr_of(p)];
`endif
    return d;
  endfunction

  // j = falling CL2 edges since scan start
  function automatic logic m_model(input int edges);
    int j;
    j = (edges / CLK_DIV) / 2;
`ifdef LCD_MLINE_EN
    return m_base ^ 1'(((j / SPL) / M_LINES) % 2);
`else
    return m_base ^ 1'((j / FRAME) % 2);
`endif
  endfunction

  task automatic check_all();
    int t, j, p;
    logic cl2_e, cl1_e, flm_e, fs_e;
    logic [DATA_W-1:0] d_e;
    t     = n / CLK_DIV;
    j     = t / 2;
    cl2_e = 1'(t % 2);
    cl1_e = (j > 0) && (j % SPL == 0) && !cl2_e;
    flm_e = (j > 0) && (((j - 1) / SPL) % LINES == 0);
    if (t == 0) begin
      d_e = '0;
    end else begin
      p   = (t - 1) / 2;
      d_e = data_of(p);
    end
    fs_e = (n > 0) && (n % CLK_DIV == 0) && cl2_e && ((((t - 1) / 2) % FRAME) == 0);
    check("cl2", 32'(lcd_cl2), 32'(cl2_e));
    check("cl1", 32'(lcd_cl1), 32'(cl1_e));
    check("flm", 32'(lcd_flm), 32'(flm_e));
    check("m", 32'(lcd_m), 32'(m_model(n)));
    check("d", 32'(lcd_d), 32'(d_e));
    check("frame_start", 32'(frame_start), 32'(fs_e));
    check("pix_addr", 32'(pix_addr), 32'(addr_of(j)));
  endtask

  initial begin
    int run;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);
`ifdef LCD_TESTPAT_EN
    testpat = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_all();
    en  = 1'b1;
    rst = 1'b0;
    run = 60;
    repeat (900) begin
      @(posedge clk);
      if (en) begin
        n++;
      end else begin
        m_base = m_model(n);
        n      = 0;
      end
      #1;
      check_all();
      if ($urandom_range(0, 149) == 0 && n > 0) begin
        rst = 1'b1;
        #1;
        n      = 0;
        m_base = 1'b0;
        check_all();
        #1;
        rst = 1'b0;
        en  = 1'b1;
        run = $urandom_range(20, 90);
      end else begin
        run--;
        if (run <= 0) begin
          en  = ~en;
          run = en ? $urandom_range(10, 90) : $urandom_range(1, 4);
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
